rx_dado_instrucao: RTL and testbench
====================================

// Module: rx_dado_instrucao
// PURPOSE
//  Serial frame receiver, the receive end of the team's one-wire dado/instrucao link.
//  Frame on the line, LSB first:
//    idle high | start (0) | dado[0..3] | instrucao[0..3] | stop (1).
//  Synchronises the line, validates start and stop, and deserialises the 8 payload bits.
//  Presents dado/instrucao with a one-cycle valido strobe to the command decoder.
// PARAMETERS
//  CLKS_POR_BIT  1  clocks per line bit; 1 matches the transmitter, which sends one bit per clk
//  N_DADO        4  dado field width
//  N_INSTR       4  instrucao field width
//  SYNC_STAGES   2  flops in the input synchroniser (>=2)
// PORTS
//  clk           in   1        single clock, rising edge
//  rst           in   1        synchronous, active-high reset
//  info_entrada  in   1        serial line, asynchronous to clk, idle high
//  dado          out  N_DADO   last good dado field
//  instrucao     out  N_INSTR  last good instrucao field
//  valido        out  1        1-cycle pulse: dado/instrucao updated
//  erro_quadro   out  1        1-cycle pulse: stop bit read as 0
//  ocupado       out  1        high whenever FSM is not OCIOSO
// BEHAVIOUR
//  Reset:
//    dado=0, instrucao=0, valido=0, erro_quadro=0, ocupado=0.
//    Synchroniser flops=1, FSM=OCIOSO, bit/clock counters=0.
//    Reset wins over every event; mid-frame reset aborts the frame and produces no pulse.
//  rx_s = info_entrada delayed by SYNC_STAGES flops; the FSM sees only rx_s.
//  MEIO = (CLKS_POR_BIT-1)/2.
//  E0 = first edge in OCIOSO where rx_s==0.
//  Sample points:
//    start checked at edge E0+MEIO (E0 itself when MEIO==0);
//    payload bit k (k=1..8) sampled at E0+MEIO+k*CLKS_POR_BIT;
//    stop sampled at E0+MEIO+9*CLKS_POR_BIT.
//  FSM states:
//    OCIOSO:      rx_s==0 -> INICIO, or directly -> DADOS when MEIO==0.
//    INICIO:      at MEIO, rx_s==1 -> OCIOSO (glitch, no output); rx_s==0 -> DADOS.
//    DADOS:       shift N_DADO+N_INSTR bits into shift register, LSB first -> PARADA.
//    PARADA:      rx_s==1 -> valido=1, dado/instrucao loaded, -> OCIOSO.
//                 rx_s==0 -> erro_quadro=1, outputs hold, -> ESPERA_ALTO.
//    ESPERA_ALTO: stay until rx_s==1 (break / stuck-low line), then -> OCIOSO; no re-trigger.
//  Output timing:
//    valido/erro_quadro are registered; high for exactly the cycle after the stop-sample edge.
//    Never both high.
//  Back-to-back frames: a start may be detected on the edge right after a good stop.
//    No idle bit required.
//  dado/instrucao change only on a good frame; they hold across errors and glitches.
//  Bit counter width ceil(log2(N_DADO+N_INSTR+1)); clock counter width ceil(log2(CLKS_POR_BIT)) (min 1).
//    Both clear on every state entry.
// STRUCTURE
//  rx_pkg:
//    FSM state localparams (OCIOSO, INICIO, DADOS, PARADA, ESPERA_ALTO);
//    frame length N_BITS_QUADRO = 1+N_DADO+N_INSTR+1;
//    line idle level 1'b1.
//  Sub-module sincronizador(SYNC_STAGES): reset-to-1 flop chain, clk/rst shared.
//  Shift register, counters and FSM stay in this module.
// TESTING
//  1) CPB=1, send dado=4'hA, instrucao=4'h3, stop=1 -> valido pulse once, dado=A, instrucao=3,
//     erro_quadro stays 0.
//  2) CPB=1, two frames back-to-back (5/C then F/0), no idle bit -> two valido pulses 10 clk apart,
//     final outputs F/0.
//  3) CPB=4, 1-clk low glitch on idle line -> no valido, no erro, ocupado returns low within MEIO+1 clk.
//  4) Frame 6/9 with stop=0, line then held low 30 clk -> one erro_quadro pulse,
//     dado/instrucao keep previous values, no new start until line high.
//  5) rst asserted at payload bit 5, then a clean frame 1/E -> aborted frame yields nothing,
//     outputs 0 after reset, then valido with 1/E.
//  6) CPB=3, sweep all 256 payload combinations -> each received value equals sent value.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared definitions for the dado/instrucao serial receiver: FSM states,
// frame geometry helpers and the line idle level.
package rx_pkg;

   // Receiver FSM states
   typedef enum logic [2:0] {
      OCIOSO      = 3'd0,
      INICIO      = 3'd1,
      DADOS       = 3'd2,
      PARADA      = 3'd3,
      ESPERA_ALTO = 3'd4
   } estado_t;

   // Level of the line when nothing is being sent
   localparam logic LINHA_OCIOSA = 1'b1;

   // Default field widths and the resulting frame length (start + payload + stop)
   localparam int N_DADO_PADRAO  = 4;
   localparam int N_INSTR_PADRAO = 4;
   localparam int N_BITS_QUADRO  = 1 + N_DADO_PADRAO + N_INSTR_PADRAO + 1;

   // Frame length for arbitrary field widths
   function automatic int bits_quadro(input int n_dado, input int n_instr);
      return 1 + n_dado + n_instr + 1;
   endfunction

   // Counter width able to hold 0..n-1, never narrower than one bit
   function automatic int largura_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rx_dado_instrucao_if.sv
// Bundle of the serial line input and the decoded-command outputs.
// master: the receiver; slave: the line driver / command decoder side.
interface rx_dado_instrucao_if #(
   parameter int N_DADO  = 4,
   parameter int N_INSTR = 4
);
   logic               info_entrada;
   logic [N_DADO-1:0]  dado;
   logic [N_INSTR-1:0] instrucao;
   logic               valido;
   logic               erro_quadro;
   logic               ocupado;

   modport master (
      input  info_entrada,
      output dado, instrucao, valido, erro_quadro, ocupado
   );

   modport slave (
      output info_entrada,
      input  dado, instrucao, valido, erro_quadro, ocupado
   );
endinterface

// File: rtl/rx_dado_instrucao_sincronizador.sv
// Input synchroniser: a chain of SYNC_STAGES flops that resets to the idle
// line level so a reset never looks like a start bit.
module sincronizador
   import rx_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] cadeia_reg;

   // Shift the asynchronous line through the flop chain
   always_ff @(posedge clk) begin
      if (rst)
         cadeia_reg <= {SYNC_STAGES{LINHA_OCIOSA}};
      else
         cadeia_reg <= {cadeia_reg[SYNC_STAGES-2:0], d};
   end

   assign q = cadeia_reg[SYNC_STAGES-1];

endmodule

// File: rtl/rx_dado_instrucao.sv
// Serial frame receiver for the dado/instrucao link.
// Frame (LSB first): start(0) | dado | instrucao | stop(1).
// Checks the start at mid-bit, samples the payload once per bit period,
// then reports a good frame (valido) or a bad stop bit (erro_quadro).
module rx_dado_instrucao
   import rx_pkg::*;
#(
   parameter int CLKS_POR_BIT = 1,
   parameter int N_DADO       = 4,
   parameter int N_INSTR      = 4,
   parameter int SYNC_STAGES  = 2
) (
   input  logic clk,
   input  logic rst,
   rx_dado_instrucao_if.master bus
);

   localparam int MEIO      = (CLKS_POR_BIT - 1) / 2;
   localparam int N_PAYLOAD = bits_quadro(N_DADO, N_INSTR) - 2;
   localparam int W_BIT     = $clog2(N_PAYLOAD + 1);
   localparam int W_CLK     = largura_min1(CLKS_POR_BIT);

   // Counter values at which the FSM acts
   localparam logic [W_CLK-1:0] ULTIMO_CLK  = W_CLK'(CLKS_POR_BIT - 1);
   localparam logic [W_CLK-1:0] ULTIMO_MEIO = (MEIO > 0) ? W_CLK'(MEIO - 1) : '0;
   localparam logic [W_BIT-1:0] ULTIMO_BIT  = W_BIT'(N_PAYLOAD - 1);

   logic                 rx_s;
   estado_t              estado_reg;
   logic [W_CLK-1:0]     cnt_clk_reg;
   logic [W_BIT-1:0]     cnt_bit_reg;
   logic [N_PAYLOAD-1:0] desloc_reg;
   logic [N_DADO-1:0]    dado_reg;
   logic [N_INSTR-1:0]   instrucao_reg;
   logic                 valido_reg;
   logic                 erro_reg;
   logic                 ocupado_reg;

   sincronizador #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sincronizador (
      .clk (clk),
      .rst (rst),
      .d   (bus.info_entrada),
      .q   (rx_s)
   );

   // Receiver FSM with counters, shift register and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         estado_reg    <= OCIOSO;
         cnt_clk_reg   <= '0;
         cnt_bit_reg   <= '0;
         desloc_reg    <= '0;
         dado_reg      <= '0;
         instrucao_reg <= '0;
         valido_reg    <= 1'b0;
         erro_reg      <= 1'b0;
         ocupado_reg   <= 1'b0;
      end else begin
         // Strobes last exactly one cycle
         valido_reg <= 1'b0;
         erro_reg   <= 1'b0;

         case (estado_reg)
            OCIOSO: begin
               cnt_clk_reg <= '0;
               cnt_bit_reg <= '0;
               if (rx_s == 1'b0) begin
                  // With MEIO==0 the start is validated on this very edge
                  estado_reg  <= (MEIO == 0) ? DADOS : INICIO;
                  ocupado_reg <= 1'b1;
               end
            end

            INICIO: begin
               if (cnt_clk_reg == ULTIMO_MEIO) begin
                  cnt_clk_reg <= '0;
                  if (rx_s == 1'b1) begin
                     // Low pulse shorter than half a bit: ignore it
                     estado_reg  <= OCIOSO;
                     ocupado_reg <= 1'b0;
                  end else begin
                     estado_reg <= DADOS;
                  end
               end else begin
                  cnt_clk_reg <= cnt_clk_reg + 1'b1;
               end
            end

            DADOS: begin
               if (cnt_clk_reg == ULTIMO_CLK) begin
                  cnt_clk_reg <= '0;
                  desloc_reg  <= {rx_s, desloc_reg[N_PAYLOAD-1:1]};
                  if (cnt_bit_reg == ULTIMO_BIT) begin
                     cnt_bit_reg <= '0;
                     estado_reg  <= PARADA;
                  end else begin
                     cnt_bit_reg <= cnt_bit_reg + 1'b1;
                  end
               end else begin
                  cnt_clk_reg <= cnt_clk_reg + 1'b1;
               end
            end

            PARADA: begin
               if (cnt_clk_reg == ULTIMO_CLK) begin
                  cnt_clk_reg <= '0;
                  if (rx_s == 1'b1) begin
                     valido_reg    <= 1'b1;
                     dado_reg      <= desloc_reg[N_DADO-1:0];
                     instrucao_reg <= desloc_reg[N_PAYLOAD-1:N_DADO];
                     estado_reg    <= OCIOSO;
                     ocupado_reg   <= 1'b0;
                  end else begin
                     // Bad stop: keep last good outputs, wait for the line to recover
                     erro_reg   <= 1'b1;
                     estado_reg <= ESPERA_ALTO;
                  end
               end else begin
                  cnt_clk_reg <= cnt_clk_reg + 1'b1;
               end
            end

            ESPERA_ALTO: begin
               cnt_clk_reg <= '0;
               cnt_bit_reg <= '0;
               if (rx_s == 1'b1) begin
                  estado_reg  <= OCIOSO;
                  ocupado_reg <= 1'b0;
               end
            end

            default: begin
               estado_reg  <= OCIOSO;
               cnt_clk_reg <= '0;
               cnt_bit_reg <= '0;
               ocupado_reg <= 1'b0;
            end
         endcase
      end
   end

   assign bus.dado        = dado_reg;
   assign bus.instrucao   = instrucao_reg;
   assign bus.valido      = valido_reg;
   assign bus.erro_quadro = erro_reg;
   assign bus.ocupado     = ocupado_reg;

endmodule

// File: tb/tb_rx_dado_instrucao.sv
// Bench for rx_dado_instrucao: three receivers (1, 3 and 4 clocks per bit)
// share clock and reset. Frames are queued as expected events and a monitor
// matches every valido/erro_quadro pulse against the queue.
module tb_rx_dado_instrucao;

   typedef struct {
      int         inst;
      bit         erro;
      logic [3:0] d;
      logic [3:0] i;
   } ev_t;

   typedef struct {
      logic [3:0] d;
      logic [3:0] i;
      bit         stop;
      int         exp_vld;
      int         exp_err;
      logic [3:0] exp_d;
      logic [3:0] exp_i;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic linha [3];

   logic [3:0] o_dado [3];
   logic [3:0] o_instr [3];
   logic       o_vld [3];
   logic       o_err [3];
   logic       o_ocup [3];

   int checks = 0;
   int errors = 0;
   int ciclo  = 0;
   int cnt_vld [3];
   int cnt_err [3];
   int ult_vld0 = 0;
   int intervalo0 = 0;
   ev_t fila [$];
   ev_t ev_mon;
   logic [3:0] esp_dado [3];
   logic [3:0] esp_instr [3];

   rx_dado_instrucao_if #(.N_DADO(4), .N_INSTR(4)) bus0 ();
   rx_dado_instrucao_if #(.N_DADO(4), .N_INSTR(4)) bus1 ();
   rx_dado_instrucao_if #(.N_DADO(4), .N_INSTR(4)) bus2 ();

   rx_dado_instrucao #(.CLKS_POR_BIT(1)) u_cpb1 (.clk(clk), .rst(rst), .bus(bus0));
   rx_dado_instrucao #(.CLKS_POR_BIT(3)) u_cpb3 (.clk(clk), .rst(rst), .bus(bus1));
   rx_dado_instrucao #(.CLKS_POR_BIT(4)) u_cpb4 (.clk(clk), .rst(rst), .bus(bus2));

   assign bus0.info_entrada = linha[0];
   assign bus1.info_entrada = linha[1];
   assign bus2.info_entrada = linha[2];

   assign o_dado[0] = bus0.dado;  assign o_instr[0] = bus0.instrucao;
   assign o_dado[1] = bus1.dado;  assign o_instr[1] = bus1.instrucao;
   assign o_dado[2] = bus2.dado;  assign o_instr[2] = bus2.instrucao;
   assign o_vld[0]  = bus0.valido; assign o_err[0] = bus0.erro_quadro; assign o_ocup[0] = bus0.ocupado;
   assign o_vld[1]  = bus1.valido; assign o_err[1] = bus1.erro_quadro; assign o_ocup[1] = bus1.ocupado;
   assign o_vld[2]  = bus2.valido; assign o_err[2] = bus2.erro_quadro; assign o_ocup[2] = bus2.ocupado;

   always #5 clk = ~clk;

   always @(posedge clk) ciclo <= ciclo + 1;

   task automatic chk(input string nome, input int atual, input int esperado);
      checks++;
      if (atual != esperado) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  nome, atual, atual, esperado, esperado, ciclo);
      end
   endtask

   function automatic int cpb_de(input int k);
      case (k)
         0:       return 1;
         1:       return 3;
         default: return 4;
      endcase
   endfunction

   // Scoreboard monitor: every pulse must match the oldest expected event
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (o_vld[k] || o_err[k]) begin
            chk("pulsos_exclusivos", int'(o_vld[k] && o_err[k]), 0);
            if (o_vld[k]) cnt_vld[k]++;
            if (o_err[k]) cnt_err[k]++;
            if (k == 0 && o_vld[k]) begin
               intervalo0 = ciclo - ult_vld0;
               ult_vld0   = ciclo;
            end
            if (fila.size() == 0) begin
               chk("pulso_inesperado", 1, 0);
            end else begin
               ev_mon = fila.pop_front();
               chk("pulso_instancia", k, ev_mon.inst);
               chk("pulso_tipo_erro", int'(o_err[k]), int'(ev_mon.erro));
               if (o_vld[k]) begin
                  chk("pulso_dado", int'(o_dado[k]), int'(ev_mon.d));
                  chk("pulso_instrucao", int'(o_instr[k]), int'(ev_mon.i));
               end
               $display("pulse inst=%0d erro=%0b dado=%0h instrucao=%0h cycle=%0d",
                        k, o_err[k], o_dado[k], o_instr[k], ciclo);
            end
         end
      end
   end

   // Queue the expected outcome, then drive the 10 line bits
   task automatic send_frame(input int k, input logic [3:0] d, input logic [3:0] i, input bit stop);
      logic [9:0] q;
      q = {stop, i, d, 1'b0};
      if (stop) begin
         fila.push_back('{k, 1'b0, d, i});
         esp_dado[k]  = d;
         esp_instr[k] = i;
      end else begin
         fila.push_back('{k, 1'b1, 4'h0, 4'h0});
      end
      for (int b = 0; b < 10; b++) begin
         linha[k] = q[b];
         repeat (cpb_de(k)) @(negedge clk);
      end
   endtask

   task automatic idle_bits(input int k, input int n);
      linha[k] = 1'b1;
      repeat (n * cpb_de(k)) @(negedge clk);
   endtask

   task automatic esperar(input int k);
      linha[k] = 1'b1;
      repeat (2 * cpb_de(k) + 8) @(negedge clk);
   endtask

   vec_t tabela [6];

   initial begin
      int v0, e0, n_ocup, gap;
      logic [3:0] rd, ri;
      bit rs;

      for (int k = 0; k < 3; k++) begin
         linha[k] = 1'b1; cnt_vld[k] = 0; cnt_err[k] = 0;
         esp_dado[k] = 4'h0; esp_instr[k] = 4'h0;
      end

      tabela[0] = '{4'hA, 4'h3, 1'b1, 1, 0, 4'hA, 4'h3};
      tabela[1] = '{4'h6, 4'h9, 1'b0, 0, 1, 4'hA, 4'h3};
      tabela[2] = '{4'h0, 4'hF, 1'b1, 1, 0, 4'h0, 4'hF};
      tabela[3] = '{4'hF, 4'hF, 1'b0, 0, 1, 4'h0, 4'hF};
      tabela[4] = '{4'h5, 4'hA, 1'b1, 1, 0, 4'h5, 4'hA};
      tabela[5] = '{4'h0, 4'h0, 1'b1, 1, 0, 4'h0, 4'h0};

      // Reset state
      rst = 1'b1;
      repeat (4) @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         chk("reset_dado", int'(o_dado[k]), 0);
         chk("reset_instrucao", int'(o_instr[k]), 0);
         chk("reset_valido", int'(o_vld[k]), 0);
         chk("reset_erro", int'(o_err[k]), 0);
         chk("reset_ocupado", int'(o_ocup[k]), 0);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // Test 1: single good frame A/3 at one clock per bit
      v0 = cnt_vld[0]; e0 = cnt_err[0];
      send_frame(0, 4'hA, 4'h3, 1'b1);
      esperar(0);
      chk("t1_valido_pulsos", cnt_vld[0] - v0, 1);
      chk("t1_erro_pulsos", cnt_err[0] - e0, 0);
      chk("t1_dado", int'(o_dado[0]), 'hA);
      chk("t1_instrucao", int'(o_instr[0]), 'h3);

      // Test 2: back-to-back frames, no idle bit
      v0 = cnt_vld[0];
      send_frame(0, 4'h5, 4'hC, 1'b1);
      send_frame(0, 4'hF, 4'h0, 1'b1);
      esperar(0);
      chk("t2_valido_pulsos", cnt_vld[0] - v0, 2);
      chk("t2_intervalo", intervalo0, 10);
      chk("t2_dado", int'(o_dado[0]), 'hF);
      chk("t2_instrucao", int'(o_instr[0]), 'h0);

      // Table-driven frames on the 4-clocks-per-bit receiver
      for (int t = 0; t < 6; t++) begin
         v0 = cnt_vld[2]; e0 = cnt_err[2];
         send_frame(2, tabela[t].d, tabela[t].i, tabela[t].stop);
         esperar(2);
         chk("tab_valido", cnt_vld[2] - v0, tabela[t].exp_vld);
         chk("tab_erro", cnt_err[2] - e0, tabela[t].exp_err);
         chk("tab_dado", int'(o_dado[2]), int'(tabela[t].exp_d));
         chk("tab_instrucao", int'(o_instr[2]), int'(tabela[t].exp_i));
         $display("vector %0d: sent %0h/%0h stop=%0b -> dado=%0h instrucao=%0h",
                  t, tabela[t].d, tabela[t].i, tabela[t].stop, o_dado[2], o_instr[2]);
      end

      // Test 3: one-clock low glitch on the 4-clocks-per-bit line
      v0 = cnt_vld[2]; e0 = cnt_err[2]; n_ocup = 0;
      linha[2] = 1'b0;
      @(negedge clk);
      linha[2] = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (o_ocup[2]) n_ocup++;
      end
      chk("t3_ocupado_breve", int'(n_ocup >= 1 && n_ocup <= 2), 1);
      chk("t3_ocupado_final", int'(o_ocup[2]), 0);
      chk("t3_valido", cnt_vld[2] - v0, 0);
      chk("t3_erro", cnt_err[2] - e0, 0);

      // Test 4: bad stop, line then held low for 30 clocks
      v0 = cnt_vld[0]; e0 = cnt_err[0];
      send_frame(0, 4'h6, 4'h9, 1'b0);
      linha[0] = 1'b0;
      repeat (30) @(negedge clk);
      chk("t4_erro_pulsos", cnt_err[0] - e0, 1);
      chk("t4_ocupado_linha_baixa", int'(o_ocup[0]), 1);
      chk("t4_dado_mantido", int'(o_dado[0]), 'hF);
      chk("t4_instrucao_mantida", int'(o_instr[0]), 'h0);
      esperar(0);
      chk("t4_ocupado_apos_alto", int'(o_ocup[0]), 0);
      chk("t4_valido", cnt_vld[0] - v0, 0);
      chk("t4_erro_final", cnt_err[0] - e0, 1);

      // Test 5: reset during payload bit 5, then a clean frame 1/E
      v0 = cnt_vld[0]; e0 = cnt_err[0];
      begin
         logic [5:0] parcial;
         parcial = {1'b0, 4'h7, 1'b0};
         for (int b = 0; b < 6; b++) begin
            linha[0] = parcial[b];
            @(negedge clk);
         end
      end
      rst = 1'b1; linha[0] = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         esp_dado[k] = 4'h0; esp_instr[k] = 4'h0;
      end
      repeat (6) @(negedge clk);
      chk("t5_nada_abortado", (cnt_vld[0] - v0) + (cnt_err[0] - e0), 0);
      chk("t5_dado_zero", int'(o_dado[0]), 0);
      chk("t5_instrucao_zero", int'(o_instr[0]), 0);
      chk("t5_ocupado_zero", int'(o_ocup[0]), 0);
      send_frame(0, 4'h1, 4'hE, 1'b1);
      esperar(0);
      chk("t5_valido", cnt_vld[0] - v0, 1);
      chk("t5_dado", int'(o_dado[0]), 'h1);
      chk("t5_instrucao", int'(o_instr[0]), 'hE);

      // Test 6: all 256 payloads at 3 clocks per bit, random gaps
      v0 = cnt_vld[1];
      for (int v = 0; v < 256; v++) begin
         rd = v[3:0]; ri = v[7:4];
         send_frame(1, rd, ri, 1'b1);
         idle_bits(1, int'($urandom_range(0, 2)));
      end
      esperar(1);
      chk("t6_valido_pulsos", cnt_vld[1] - v0, 256);
      chk("t6_dado_final", int'(o_dado[1]), 'hF);
      chk("t6_instrucao_final", int'(o_instr[1]), 'hF);

      // Randomized frames with occasional bad stop bits on the 4-clocks-per-bit line
      for (int n = 0; n < 30; n++) begin
         rd = 4'($urandom);
         ri = 4'($urandom);
         rs = ($urandom_range(0, 7) != 0);
         send_frame(2, rd, ri, rs);
         gap = rs ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 3));
         idle_bits(2, gap);
      end
      esperar(2);
      chk("rand_dado", int'(o_dado[2]), int'(esp_dado[2]));
      chk("rand_instrucao", int'(o_instr[2]), int'(esp_instr[2]));
      chk("rand_ocupado", int'(o_ocup[2]), 0);

      chk("fila_vazia", fila.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
